// File: rtl/io_mmio_if.sv
// Core-side IO bus between the execute/memory stages and io_mmio.
// The master drives the address and strobes; the slave returns registered read data.
interface io_mmio_if #(
    parameter int ADR_W = 8
);
    logic [ADR_W-1:0] io_adr;
    logic             iowea;
    logic             io_rd;
    logic [31:0]      io_wdata;
    logic [31:0]      io_rdata;

    modport master (
        output io_adr, iowea, io_rd, io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_adr, iowea, io_rd, io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/io_mmio.sv
// Memory-mapped IO: UART TX holding register, RX FIFO, cycle/instret counters.
// Counters and the 0x18 clear register exist only when IO_COUNTERS_EN is defined.
module io_mmio #(
    parameter int RX_DEPTH = 8,
    parameter int ADR_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    io_mmio_if.slave   bus,
    input  logic       inst_retire,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_valid,
    input  logic       uart_tx_ready,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_valid,
    output logic       uart_rx_ready
);
    localparam int PW = $clog2(RX_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(RX_DEPTH);

    localparam logic [ADR_W-1:0] A_STAT = ADR_W'(8'h00);
    localparam logic [ADR_W-1:0] A_RX   = ADR_W'(8'h04);
    localparam logic [ADR_W-1:0] A_TX   = ADR_W'(8'h08);
    localparam logic [ADR_W-1:0] A_CYC  = ADR_W'(8'h10);
    localparam logic [ADR_W-1:0] A_RET  = ADR_W'(8'h14);

    logic [ADR_W-1:0] wadr;
    logic             sel_stat, sel_rx, sel_tx, sel_cyc, sel_ret;
    logic [7:0]       tx_data;
    logic             tx_full;
    logic             tx_load;
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [PW:0]      rx_cnt;
    logic             rx_empty;
    logic             push, pop;
    logic [31:0]      cyc_rd, ret_rd;
    logic [31:0]      rdata_d;
    logic             unused_bits;

    assign wadr     = {bus.io_adr[ADR_W-1:2], 2'b00};
    assign sel_stat = (wadr == A_STAT);
    assign sel_rx   = (wadr == A_RX);
    assign sel_tx   = (wadr == A_TX);
    assign sel_cyc  = (wadr == A_CYC);
    assign sel_ret  = (wadr == A_RET);

    assign rx_empty      = (rx_cnt == '0);
    assign uart_rx_ready = (rx_cnt != CNT_FULL);
    assign push          = uart_rx_valid && uart_rx_ready;
    assign pop           = bus.io_rd && sel_rx && !rx_empty;

    // Full check uses pre-edge tx_full, so a write during the handshake drops
    assign tx_load       = bus.iowea && sel_tx && !tx_full;
    assign uart_tx_valid = tx_full;
    assign uart_tx_data  = tx_data;

    // TX holding register and its full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full <= 1'b0;
            tx_data <= 8'h00;
        end else if (tx_load) begin
            tx_full <= 1'b1;
            tx_data <= bus.io_wdata[7:0];
        end else if (tx_full && uart_tx_ready) begin
            tx_full <= 1'b0;
        end
    end

    // RX FIFO storage; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) rx_mem[wr_ptr] <= uart_rx_data;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            rx_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (pop && !push) rx_cnt <= rx_cnt - 1'b1;
        end
    end

`ifdef IO_COUNTERS_EN
    localparam logic [ADR_W-1:0] A_CLR = ADR_W'(8'h18);
    logic [31:0] cyc_cnt, ret_cnt;
    logic        cnt_clr;

    assign cnt_clr = bus.iowea && (wadr == A_CLR);

    // Free-running counters; a clear write wins over the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (inst_retire) ret_cnt <= ret_cnt + 1'b1;
        end
    end

    assign cyc_rd = cyc_cnt;
    assign ret_rd = ret_cnt;
    assign unused_bits = ^{bus.io_wdata[31:8], bus.io_adr[1:0]};
`else
    assign cyc_rd = '0;
    assign ret_rd = '0;
    assign unused_bits = ^{bus.io_wdata[31:8], bus.io_adr[1:0], inst_retire};
`endif

    // Read mux over pre-edge state
    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
            sel_stat: rdata_d = {30'b0, !rx_empty, !tx_full};
            sel_rx:   rdata_d = rx_empty ? 32'h0 : {24'b0, rx_mem[rd_ptr]};
            sel_cyc:  rdata_d = cyc_rd;
            sel_ret:  rdata_d = ret_rd;
            default:  rdata_d = '0;
        endcase
    end

    // One-cycle registered read data for the memory-stage load mux
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.io_rdata <= '0;
        else        bus.io_rdata <= rdata_d;
    end
endmodule
